alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Parametrised, handshaked successor to the single-cycle execute-stage ALU. It keeps the same 3-bit operation encoding. It adds a registered result, valid/ready flow control on both sides, and a width-independent iterative shift-add multiplier in place of a combinational multiply. It sits between the ID/EX register and EX/MEM, and lets the pipeline stall on multi-cycle operations.

## Interface
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHAMT_W, $clog2(WIDTH), derived; shift-amount bits taken from data2_i. Do not override.
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  operation request valid.
- ready_o  output  1  block can accept a request this cycle.
- data1_i  input  WIDTH  operand A.
- data2_i  input  WIDTH  operand B.
- ALUCtrl_i  input  3  operation select.
- valid_o  output  1  data_o/Zero_o hold a result.
- ready_i  input  1  consumer takes the result this cycle.
- data_o  output  WIDTH  registered result.
- Zero_o  output  1  registered; 1 when the result equals 0.
- busy_o  output  1  multiplier iteration in progress (state MUL).

## Operation
- Opcodes: 000 AND; 001 XOR; 010 SLL by data2_i[SHAMT_W-1:0]; 011 ADD; 100 SUB (A-B, modulo 2^WIDTH); 101 MUL, low WIDTH bits of the unsigned product, which equal the low bits of the signed product; 110 ADD (immediate path, same as 011); 111 SRA (arithmetic, sign of data1_i) by data2_i[SHAMT_W-1:0].
- Only the low SHAMT_W bits of data2_i affect shifts. Upper bits are ignored.
- Operands and ALUCtrl_i are captured only on accept (valid_i && ready_o). They may change freely at any other time.
- States: IDLE, MUL.
  - IDLE: ready_o = !valid_o || ready_i.
  - On accepting a non-MUL op: load data_o/Zero_o and set valid_o; stay in IDLE.
  - On accepting MUL: latch multiplicand = data1_i, multiplier = data2_i, acc = 0, count = WIDTH; go to MUL; valid_o clears at the same edge (a pending result is necessarily consumed that cycle).
  - MUL: ready_o = 0 and busy_o = 1.
  - MUL, each cycle: if multiplier[0] is set, acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; count -= 1.
  - MUL exit: on the edge where count goes 1 -> 0, data_o = final acc (including that iteration), Zero_o = (final acc == 0), valid_o = 1, state -> IDLE.
  - MUL has no early exit: latency is fixed regardless of operand values.
- Output register:
  - While valid_o = 1 and ready_i = 0, data_o/Zero_o/valid_o hold.
  - When valid_o && ready_i and no new accept occurs, valid_o clears; data_o/Zero_o keep their last value.
- Zero_o is meaningful only while valid_o = 1.
- Invalid or X ALUCtrl_i is impossible: all 8 codes are defined.

## Timing
- Reset (rst_i = 1 at an edge):
  - Outputs: valid_o = 0, data_o = 0, Zero_o = 0, busy_o = 0, ready_o = 1 after the edge.
  - Internal: state = IDLE, count = 0, acc = 0.
- Reset overrides everything, including an in-flight MUL and a simultaneous accept. An aborted MUL produces no result.
- Single-cycle ops: request accepted at edge E0; result is valid after E0, so latency is 1.
  - Back-to-back throughput is 1 op/cycle when ready_i stays high.
- MUL: accepted at E0; iterations at E1..E_WIDTH; valid_o rises after E_WIDTH, so latency is WIDTH+1 cycles (33 for WIDTH = 32).
  - The next request is accepted no earlier than the cycle after valid_o rises, and only if ready_i permits.
- Simultaneous consume and accept in IDLE (valid_o && ready_i && valid_i): the old result retires and the new one replaces it with no bubble. For MUL, valid_o drops for the iteration cycles.
- ready_o is combinational from state, valid_o and ready_i. There is no path from valid_i to ready_o.
- The consumer must not make ready_i depend combinationally on ready_o.

## Test plan
- Reset then ADD 5+7 (011) with ready_i = 1: valid_o after 1 edge, data_o = 12, Zero_o = 0. Repeat with 110: same result.
- SUB 0x1234-0x1234: data_o = 0, Zero_o = 1. SUB 0-1: data_o = 0xFFFFFFFF.
- SRA 0x80000000 by data2 = 0x24: shift is 4, data_o = 0xF8000000. SLL 1 by 33: data_o = 2.
- MUL 0xFFFFFFFF×3: busy_o high for exactly 32 cycles, ready_o = 0 throughout, then valid_o with data_o = 0xFFFFFFFD. MUL 0×5: data_o = 0, Zero_o = 1, still 33-cycle latency.
- Backpressure: hold ready_i = 0 for 5 cycles after an AND result. data_o/valid_o must stay stable and ready_o = 0. Raise ready_i with a new XOR valid_i in the same cycle: XOR result appears next edge with no gap.
- Assert rst_i at MUL iteration 10: after the edge valid_o = 0, busy_o = 0, ready_o = 1, data_o = 0. A following ADD 1+1 returns 2 after 1 cycle.

Source files
------------

// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if: request/result handshake bundle for alu_multicycle.
//   Request side : valid_i, ready_o, data1_i, data2_i, ALUCtrl_i
//   Result side  : valid_o, ready_i, data_o, Zero_o
//   Status       : busy_o (multiplier iterating)
// slave modport is the ALU's view; master modport is the driver/consumer's view.
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic [2:0]       ALUCtrl_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] data_o;
    logic             Zero_o;
    logic             busy_o;

    modport slave (
        input  valid_i, data1_i, data2_i, ALUCtrl_i, ready_i,
        output ready_o, valid_o, data_o, Zero_o, busy_o
    );

    modport master (
        output valid_i, data1_i, data2_i, ALUCtrl_i, ready_i,
        input  ready_o, valid_o, data_o, Zero_o, busy_o
    );
endinterface

// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked execute-stage ALU with a registered result and a
// fixed-latency iterative shift-add multiplier.
// Ports:
//   clk_i  - clock, all state updates on the rising edge
//   rst_i  - synchronous active-high reset
//   bus    - alu_multicycle_if.slave (request, result and busy signals)
// Single-cycle ops deliver a result one edge after accept; MUL takes WIDTH+1.
module alu_multicycle #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    alu_multicycle_if.slave     bus
);
    localparam int COUNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_SLL  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_ADDI = 3'b110;
    localparam logic [2:0] OP_SRA  = 3'b111;

    typedef enum logic {IDLE, MUL} state_t;

    state_t               state, state_n;
    logic                 valid_q;
    logic [WIDTH-1:0]     data_q;
    logic                 zero_q;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [COUNT_W-1:0]   count;
    logic                 ready;
    logic                 busy;
    logic                 accept;
    logic [WIDTH-1:0]     comb_res;
    logic [WIDTH-1:0]     acc_next;

    // Single-cycle result; MUL is handled by the iterative datapath instead.
    function automatic logic [WIDTH-1:0] alu_comb(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic signed [WIDTH-1:0] a_s;
        logic [SHAMT_W-1:0]      sh;
        logic [WIDTH-1:0]        r;
        a_s = a;
        sh  = b[SHAMT_W-1:0];
        r   = '0;
        case (op)
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << sh;
            OP_ADD,
            OP_ADDI: r = a + b;
            OP_SUB:  r = a - b;
            OP_SRA:  r = a_s >>> sh;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign accept   = bus.valid_i && ready;
    assign comb_res = alu_comb(bus.ALUCtrl_i, bus.data1_i, bus.data2_i);
    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // ready_o depends only on state, valid_o and ready_i, never on valid_i.
    always_comb begin
        state_n = state;
        ready   = 1'b0;
        busy    = 1'b0;
        case (state)
            IDLE: begin
                ready = !valid_q || bus.ready_i;
                if (accept && bus.ALUCtrl_i == OP_MUL) begin
                    state_n = MUL;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (count == COUNT_W'(1)) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                if (bus.ALUCtrl_i == OP_MUL) begin
                    mcand   <= bus.data1_i;
                    mplier  <= bus.data2_i;
                    acc     <= '0;
                    count   <= COUNT_W'(WIDTH);
                    valid_q <= 1'b0;
                end else begin
                    data_q  <= comb_res;
                    zero_q  <= (comb_res == '0);
                    valid_q <= 1'b1;
                end
            end else if (valid_q && bus.ready_i) begin
                valid_q <= 1'b0;
            end
        end else begin
            // One shift-add step per cycle; fixed WIDTH iterations, no early exit.
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - COUNT_W'(1);
            if (count == COUNT_W'(1)) begin
                data_q  <= acc_next;
                zero_q  <= (acc_next == '0);
                valid_q <= 1'b1;
            end
        end
    end

    assign bus.ready_o = ready;
    assign bus.busy_o  = busy;
    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;
    assign bus.Zero_o  = zero_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed self-checking bench for alu_multicycle (WIDTH=32).
module tb_alu_multicycle;
    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    alu_multicycle_if #(.WIDTH(WIDTH)) bus ();

    alu_multicycle #(.WIDTH(WIDTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request for a single edge, then withdraw it; returns 1 ns after the edge.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.valid_i   = 1'b1;
        bus.ALUCtrl_i = op;
        bus.data1_i   = a;
        bus.data2_i   = b;
        @(posedge clk);
        #1;
        bus.valid_i   = 1'b0;
        bus.data1_i   = 32'hDEAD_BEEF;
        bus.data2_i   = 32'h0BAD_F00D;
        bus.ALUCtrl_i = 3'b010;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        bus.data1_i = '0;
        bus.data2_i = '0;
        bus.ALUCtrl_i = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.valid_o); end
        checks++; if (bus.data_o !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", bus.data_o); end
        checks++; if (bus.Zero_o !== 1'b0) begin errors++; $display("FAIL reset_zero got=%b exp=0", bus.Zero_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.ready_o); end
    endtask

    task automatic test_add();
        do_op(3'b011, 32'd5, 32'd7);
        checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", bus.valid_o); end
        checks++; if (bus.data_o !== 32'd12) begin errors++; $display("FAIL add_data got=%h exp=%h", bus.data_o, 32'd12); end
        checks++; if (bus.Zero_o !== 1'b0) begin errors++; $display("FAIL add_zero got=%b exp=0", bus.Zero_o); end
        do_op(3'b110, 32'd5, 32'd7);
        checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL addi_valid got=%b exp=1", bus.valid_o); end
        checks++; if (bus.data_o !== 32'd12) begin errors++; $display("FAIL addi_data got=%h exp=%h", bus.data_o, 32'd12); end
    endtask

    task automatic test_sub();
        do_op(3'b100, 32'h1234, 32'h1234);
        checks++; if (bus.data_o !== 32'h0) begin errors++; $display("FAIL sub_eq_data got=%h exp=0", bus.data_o); end
        checks++; if (bus.Zero_o !== 1'b1) begin errors++; $display("FAIL sub_eq_zero got=%b exp=1", bus.Zero_o); end
        do_op(3'b100, 32'h0, 32'h1);
        checks++; if (bus.data_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_wrap_data got=%h exp=ffffffff", bus.data_o); end
        checks++; if (bus.Zero_o !== 1'b0) begin errors++; $display("FAIL sub_wrap_zero got=%b exp=0", bus.Zero_o); end
    endtask

    task automatic test_logic_shift();
        do_op(3'b000, 32'h0000_F0F0, 32'h0000_FF00);
        checks++; if (bus.data_o !== 32'h0000_F000) begin errors++; $display("FAIL and_data got=%h exp=0000f000", bus.data_o); end
        do_op(3'b001, 32'h0000_FF00, 32'h0000_0FF0);
        checks++; if (bus.data_o !== 32'h0000_F0F0) begin errors++; $display("FAIL xor_data got=%h exp=0000f0f0", bus.data_o); end
        do_op(3'b111, 32'h8000_0000, 32'h0000_0024);
        checks++; if (bus.data_o !== 32'hF800_0000) begin errors++; $display("FAIL sra_data got=%h exp=f8000000", bus.data_o); end
        do_op(3'b111, 32'h4000_0000, 32'h0000_0004);
        checks++; if (bus.data_o !== 32'h0400_0000) begin errors++; $display("FAIL sra_pos_data got=%h exp=04000000", bus.data_o); end
        do_op(3'b010, 32'h0000_0001, 32'd33);
        checks++; if (bus.data_o !== 32'h0000_0002) begin errors++; $display("FAIL sll_data got=%h exp=00000002", bus.data_o); end
    endtask

    task automatic test_mul();
        int busy_cycles;
        int ready_bad;
        int lat;
        busy_cycles = 0;
        ready_bad   = 0;
        do_op(3'b101, 32'hFFFF_FFFF, 32'h3);
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL mul_valid_drop got=%b exp=0", bus.valid_o); end
        while (bus.busy_o === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            if (bus.ready_o !== 1'b0) ready_bad++;
            @(posedge clk);
            #1;
        end
        checks++; if (busy_cycles != 32) begin errors++; $display("FAIL mul_busy_cycles got=%0d exp=32", busy_cycles); end
        checks++; if (ready_bad != 0) begin errors++; $display("FAIL mul_ready_low got=%0d_cycles_high exp=0", ready_bad); end
        checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL mul_valid got=%b exp=1", bus.valid_o); end
        checks++; if (bus.data_o !== 32'hFFFF_FFFD) begin errors++; $display("FAIL mul_data got=%h exp=fffffffd", bus.data_o); end

        do_op(3'b101, 32'h0, 32'h5);
        lat = 1;
        while (bus.valid_o !== 1'b1 && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++; if (lat != 33) begin errors++; $display("FAIL mul0_latency got=%0d exp=33", lat); end
        checks++; if (bus.data_o !== 32'h0) begin errors++; $display("FAIL mul0_data got=%h exp=0", bus.data_o); end
        checks++; if (bus.Zero_o !== 1'b1) begin errors++; $display("FAIL mul0_zero got=%b exp=1", bus.Zero_o); end

        do_op(3'b101, 32'hFFFF_FFF9, 32'd6);
        lat = 1;
        while (bus.valid_o !== 1'b1 && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++; if (bus.data_o !== 32'hFFFF_FFD6) begin errors++; $display("FAIL mul_neg_data got=%h exp=ffffffd6", bus.data_o); end
    endtask

    task automatic test_backpressure();
        int unstable;
        unstable = 0;
        bus.ready_i = 1'b1;
        do_op(3'b000, 32'h0000_F0F0, 32'h0000_FF00);
        bus.ready_i = 1'b0;
        #1;
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0", bus.ready_o); end
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.valid_o !== 1'b1 || bus.data_o !== 32'h0000_F000 || bus.ready_o !== 1'b0) unstable++;
        end
        checks++; if (unstable != 0) begin errors++; $display("FAIL bp_hold got=%0d_bad_cycles exp=0", unstable); end
        bus.ready_i = 1'b1;
        #1;
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", bus.ready_o); end
        do_op(3'b001, 32'h0000_FF00, 32'h0000_0FF0);
        checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL bp_xor_valid got=%b exp=1", bus.valid_o); end
        checks++; if (bus.data_o !== 32'h0000_F0F0) begin errors++; $display("FAIL bp_xor_data got=%h exp=0000f0f0", bus.data_o); end
        @(posedge clk);
        #1;
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL consume_valid got=%b exp=0", bus.valid_o); end
        checks++; if (bus.data_o !== 32'h0000_F0F0) begin errors++; $display("FAIL consume_data_hold got=%h exp=0000f0f0", bus.data_o); end
    endtask

    task automatic test_reset_mid_mul();
        do_op(3'b101, 32'd7, 32'd9);
        repeat (9) @(posedge clk);
        #1;
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL abort_busy_before got=%b exp=1", bus.busy_o); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL abort_valid got=%b exp=0", bus.valid_o); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bus.busy_o); end
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", bus.ready_o); end
        checks++; if (bus.data_o !== 32'h0) begin errors++; $display("FAIL abort_data got=%h exp=0", bus.data_o); end
        do_op(3'b011, 32'd1, 32'd1);
        checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL post_abort_valid got=%b exp=1", bus.valid_o); end
        checks++; if (bus.data_o !== 32'd2) begin errors++; $display("FAIL post_abort_data got=%h exp=2", bus.data_o); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        test_reset();
        test_add();
        test_sub();
        test_logic_shift();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
